// File: rtl/text_line_ctrl_if.sv
// Keyboard command channel for text_line_ctrl.
//   valid : sender has a command on op/code
//   ready : receiver accepts it this cycle (transfer on valid && ready)
//   op    : 00 put char, 01 backspace, 10 clear, 11 reserved
//   code  : character code for put (1..26 = A..Z, 0 = blank)
interface text_line_ctrl_if;
  logic       valid;
  logic       ready;
  logic [1:0] op;
  logic [4:0] code;

  modport master (
    output valid,
    output op,
    output code,
    input  ready
  );

  modport slave (
    input  valid,
    input  op,
    input  code,
    output ready
  );
endinterface

// File: rtl/text_line_ctrl.sv
// One line of text on the VGA output.
// Holds a NUM_CHARS character buffer written through a valid/ready command channel
// (put, backspace, clear), and runs a free-running two-stage render pipeline that maps
// the current pixel to a buffer cell, addresses the glyph ROM and extracts the pixel bit.
// Ports:
//   clk, rst            pixel clock, asynchronous active-low reset
//   cmd                 command channel (slave side)
//   pix_x, pix_y        current pixel coordinate from VGA timing
//   de_in, hsync_in,
//   vsync_in            timing inputs
//   rom_address         glyph ROM address (code of the stage-1 cell)
//   rom_data            glyph ROM data, 32 rows x 16 bits, bit 0 of a row = leftmost
//   pix_on              foreground pixel, 2 cycles after its coordinate
//   de_out, hsync_out,
//   vsync_out           timing inputs delayed 2 cycles
//   cursor              next write cell, 0..NUM_CHARS
//   busy                high while a clear is sweeping the buffer
module text_line_ctrl #(
  parameter int unsigned NUM_CHARS = 40,
  parameter int unsigned X0        = 0,
  parameter int unsigned Y0        = 224
) (
  input  logic                   clk,
  input  logic                   rst,
  text_line_ctrl_if.slave        cmd,
  input  logic [9:0]             pix_x,
  input  logic [9:0]             pix_y,
  input  logic                   de_in,
  input  logic                   hsync_in,
  input  logic                   vsync_in,
  output logic [9:0]             rom_address,
  input  logic [511:0]           rom_data,
  output logic                   pix_on,
  output logic                   de_out,
  output logic                   hsync_out,
  output logic                   vsync_out,
  output logic [5:0]             cursor,
  output logic                   busy
);

  localparam logic [1:0] OpPut   = 2'b00;
  localparam logic [1:0] OpBksp  = 2'b01;
  localparam logic [1:0] OpClear = 2'b10;

  localparam logic [5:0]  MaxCur  = 6'(NUM_CHARS);
  localparam logic [10:0] XStart  = 11'(X0);
  localparam logic [10:0] XEnd    = 11'(X0 + 16 * NUM_CHARS);
  localparam logic [10:0] YStart  = 11'(Y0);
  localparam logic [10:0] YEnd    = 11'(Y0 + 32);

  typedef enum logic [0:0] {StIdle, StClear} state_e;

  state_e     state_q;
  logic [5:0] cursor_q;
  logic [5:0] clr_idx_q;
  logic       busy_q;

  logic [4:0] char_q [NUM_CHARS];

  logic       accept;
  logic       wr_en;
  logic [5:0] wr_idx;
  logic [4:0] wr_val;

  assign cmd.ready = (state_q == StIdle);
  assign accept    = cmd.valid && cmd.ready;
  assign cursor    = cursor_q;
  assign busy      = busy_q;

  // Single buffer write port shared by put, backspace and the clear sweep.
  always_comb begin
    wr_en  = 1'b0;
    wr_idx = '0;
    wr_val = '0;
    if (state_q == StClear) begin
      wr_en  = 1'b1;
      wr_idx = clr_idx_q;
    end else if (accept) begin
      case (cmd.op)
        OpPut: begin
          if (cursor_q < MaxCur) begin
            wr_en  = 1'b1;
            wr_idx = cursor_q;
            wr_val = (cmd.code <= 5'd26) ? cmd.code : 5'd0;
          end
        end
        OpBksp: begin
          if (cursor_q != '0) begin
            wr_en  = 1'b1;
            wr_idx = cursor_q - 6'd1;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NUM_CHARS; i++) char_q[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_CHARS; i++) begin
        if (wr_en && wr_idx == 6'(i)) char_q[i] <= wr_val;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= StIdle;
      cursor_q  <= '0;
      clr_idx_q <= '0;
      busy_q    <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (accept) begin
            case (cmd.op)
              OpPut:   if (cursor_q < MaxCur) cursor_q <= cursor_q + 6'd1;
              OpBksp:  if (cursor_q != '0) cursor_q <= cursor_q - 6'd1;
              OpClear: begin
                state_q   <= StClear;
                clr_idx_q <= '0;
                busy_q    <= 1'b1;
              end
              default: ;
            endcase
          end
        end
        StClear: begin
          clr_idx_q <= clr_idx_q + 6'd1;
          if (clr_idx_q == MaxCur - 6'd1) begin
            cursor_q <= '0;
            state_q  <= StIdle;
            busy_q   <= 1'b0;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  // Render stage 1: coordinate decode. Widened to 11 bits so pix_x < X0 never wraps in range.
  logic [10:0] px, py, dx;
  logic [6:0]  cell_d;
  logic [4:0]  row_d;
  logic        in_text_d;
  logic [4:0]  code_d;

  assign px        = {1'b0, pix_x};
  assign py        = {1'b0, pix_y};
  assign dx        = px - XStart;
  assign cell_d    = dx[10:4];
  assign row_d     = 5'(py - YStart);
  assign in_text_d = de_in && (px >= XStart) && (px < XEnd) && (py >= YStart) && (py < YEnd);

  // Registered buffer read: a same-cycle write to this cell is seen next cycle.
  always_comb begin
    code_d = '0;
    for (int i = 0; i < NUM_CHARS; i++) begin
      if (in_text_d && cell_d == 7'(i)) code_d = char_q[i];
    end
  end

  logic       in_text1_q, de1_q, hsync1_q, vsync1_q;
  logic [3:0] col1_q;
  logic [4:0] row1_q;
  logic [4:0] code1_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      in_text1_q <= 1'b0;
      col1_q     <= '0;
      row1_q     <= '0;
      code1_q    <= '0;
      de1_q      <= 1'b0;
      hsync1_q   <= 1'b0;
      vsync1_q   <= 1'b0;
    end else begin
      in_text1_q <= in_text_d;
      col1_q     <= dx[3:0];
      row1_q     <= row_d;
      code1_q    <= code_d;
      de1_q      <= de_in;
      hsync1_q   <= hsync_in;
      vsync1_q   <= vsync_in;
    end
  end

  assign rom_address = {5'b0, code1_q};

  // Render stage 2: glyph bit at row*16 + col.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pix_on    <= 1'b0;
      de_out    <= 1'b0;
      hsync_out <= 1'b0;
      vsync_out <= 1'b0;
    end else begin
      pix_on    <= in_text1_q && rom_data[{row1_q, col1_q}];
      de_out    <= de1_q;
      hsync_out <= hsync1_q;
      vsync_out <= vsync1_q;
    end
  end

endmodule

// File: tb/tb_text_line_ctrl.sv
module tb_text_line_ctrl;
  localparam int NC = 40;
  localparam int X0 = 0;
  localparam int Y0 = 224;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic [9:0]   pix_x = '0;
  logic [9:0]   pix_y = '0;
  logic         de_in = 1'b0;
  logic         hsync_in = 1'b0;
  logic         vsync_in = 1'b0;
  logic [9:0]   rom_address;
  logic [511:0] rom_data;
  logic         pix_on, de_out, hsync_out, vsync_out, busy;
  logic [5:0]   cursor;

  text_line_ctrl_if cmd_if();

  text_line_ctrl #(.NUM_CHARS(NC), .X0(X0), .Y0(Y0)) dut (
    .clk        (clk),
    .rst        (rst),
    .cmd        (cmd_if),
    .pix_x      (pix_x),
    .pix_y      (pix_y),
    .de_in      (de_in),
    .hsync_in   (hsync_in),
    .vsync_in   (vsync_in),
    .rom_address(rom_address),
    .rom_data   (rom_data),
    .pix_on     (pix_on),
    .de_out     (de_out),
    .hsync_out  (hsync_out),
    .vsync_out  (vsync_out),
    .cursor     (cursor),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  bit chk_en = 0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, want 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Glyph table; code 1 row 16 is the A crossbar, columns 2..13.
  function automatic logic [15:0] glyph_row(input int code, input int row);
    int unsigned h;
    if (code <= 0 || code > 26) return 16'h0;
    if (code == 1 && row == 16) return 16'h3FFC;
    h = (32'(code) * 32'h9E3779B1) ^ (32'(row) * 32'h85EBCA6B);
    h = h ^ (h >> 15);
    return h[15:0];
  endfunction

  always_comb begin
    rom_data = '0;
    for (int r = 0; r < 32; r++) rom_data[r*16 +: 16] = glyph_row(int'(rom_address), r);
  end

  // Reference model: buffer contents, cursor, clear countdown, 2-deep output delay.
  int m_buf [NC];
  int m_cursor;
  int m_clr_left;
  int e1_code;
  bit e1_pix, e1_de, e1_hs, e1_vs;
  bit e2_pix, e2_de, e2_hs, e2_vs;

  function automatic bit in_text_now();
    return de_in && int'(pix_x) >= X0 && int'(pix_x) < X0 + 16 * NC &&
           int'(pix_y) >= Y0 && int'(pix_y) < Y0 + 32;
  endfunction

  function automatic int code_now();
    if (!in_text_now()) return 0;
    return m_buf[(int'(pix_x) - X0) / 16];
  endfunction

  function automatic bit pix_now();
    logic [15:0] g;
    if (!in_text_now()) return 1'b0;
    g = glyph_row(code_now(), int'(pix_y) - Y0);
    return g[(int'(pix_x) - X0) % 16];
  endfunction

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NC; i++) m_buf[i] <= 0;
      m_cursor <= 0; m_clr_left <= 0; e1_code <= 0;
      e1_pix <= 0; e1_de <= 0; e1_hs <= 0; e1_vs <= 0;
      e2_pix <= 0; e2_de <= 0; e2_hs <= 0; e2_vs <= 0;
    end else begin
      e1_code <= code_now();
      e1_pix <= pix_now(); e1_de <= de_in; e1_hs <= hsync_in; e1_vs <= vsync_in;
      e2_pix <= e1_pix; e2_de <= e1_de; e2_hs <= e1_hs; e2_vs <= e1_vs;
      if (m_clr_left == 0) begin
        if (cmd_if.valid) begin
          case (cmd_if.op)
            2'b00: if (m_cursor < NC) begin
              m_buf[m_cursor] <= (cmd_if.code <= 26) ? int'(cmd_if.code) : 0;
              m_cursor <= m_cursor + 1;
            end
            2'b01: if (m_cursor > 0) begin
              m_buf[m_cursor - 1] <= 0;
              m_cursor <= m_cursor - 1;
            end
            2'b10: m_clr_left <= NC;
            default: ;
          endcase
        end
      end else begin
        m_buf[NC - m_clr_left] <= 0;
        m_clr_left <= m_clr_left - 1;
        if (m_clr_left == 1) m_cursor <= 0;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("render", int'({pix_on, de_out, hsync_out, vsync_out}),
            int'({e2_pix, e2_de, e2_hs, e2_vs}));
      check("rom_address", int'(rom_address), e1_code);
      check("cmd_state", int'({cmd_if.ready, busy, cursor}),
            int'({m_clr_left == 0, m_clr_left != 0, 6'(m_cursor)}));
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic do_cmd(input logic [1:0] op, input logic [4:0] code);
    int n = 0;
    bit rdy;
    cmd_if.valid = 1'b1; cmd_if.op = op; cmd_if.code = code;
    do begin
      rdy = cmd_if.ready;
      tick();
      n++;
    end while (!rdy && n < 200);
    if (!rdy) check("cmd_accept_timeout", 0, 1);
    cmd_if.valid = 1'b0;
  endtask

  initial begin
    int cnt;
    int sum;
    bit rdy_before;
    cmd_if.valid = 1'b0; cmd_if.op = '0; cmd_if.code = '0;
    tick(); tick(); tick();
    chk_en = 1;
    check("reset_cursor", int'(cursor), 0);
    check("reset_busy", int'(busy), 0);
    check("reset_outputs", int'({pix_on, de_out, hsync_out, vsync_out}), 0);
    rst = 1'b1;
    tick();

    // A, B, C then scan crossbar row through cell 0..2.
    do_cmd(2'b00, 5'd1); do_cmd(2'b00, 5'd2); do_cmd(2'b00, 5'd3);
    check("cursor_after_abc", int'(cursor), 3);
    pix_y = 10'(Y0 + 16); de_in = 1'b1;
    for (int k = 0; k < 50; k++) begin
      if (k >= 2 && k < 18) check("a_crossbar", int'(pix_on), int'(k - 2 >= 2 && k - 2 <= 13));
      pix_x = 10'(k);
      tick();
    end
    pix_x = 10'd20; pix_y = 10'(Y0);
    tick();
    check("rom_addr_cell1", int'(rom_address), 2);

    // Saturation at NUM_CHARS.
    for (int i = 0; i < 41; i++) do_cmd(2'b00, 5'(i % 27));
    check("cursor_saturate", int'(cursor), 40);

    // Clear from full line with a put held across it.
    do_cmd(2'b10, 5'd0);
    cmd_if.valid = 1'b1; cmd_if.op = 2'b00; cmd_if.code = 5'd7;
    cnt = 0;
    while (!cmd_if.ready && cnt < 100) begin
      cnt++;
      tick();
    end
    check("clear_cycles", cnt, 40);
    tick();
    cmd_if.valid = 1'b0;
    check("held_put_cursor", int'(cursor), 1);
    pix_x = 10'd3; pix_y = 10'(Y0);
    tick();
    check("held_put_code", int'(rom_address), 7);

    // Out-of-range code stored as blank.
    do_cmd(2'b10, 5'd0);
    do_cmd(2'b00, 5'd30);
    tick();
    check("code30_blank", int'(rom_address), 0);

    // Backspace behaviour.
    do_cmd(2'b01, 5'd0);
    do_cmd(2'b01, 5'd0);
    check("bksp_at_zero", int'(cursor), 0);
    do_cmd(2'b00, 5'd5);
    do_cmd(2'b01, 5'd0);
    check("put_bksp_cursor", int'(cursor), 0);
    tick();
    check("put_bksp_blank", int'(rom_address), 0);

    // Outside the line and sync pass-through.
    do_cmd(2'b00, 5'd9);
    pix_x = 10'd5; pix_y = 10'(Y0 - 1); tick();
    pix_y = 10'(Y0 + 32); tick();
    pix_x = 10'd640; pix_y = 10'(Y0 + 3); tick();
    pix_x = 10'd5; de_in = 1'b0; tick();
    de_in = 1'b1; hsync_in = 1'b1; vsync_in = 1'b1;
    tick();
    hsync_in = 1'b0; vsync_in = 1'b0;
    check("hsync_lat1", int'(hsync_out), 0);
    tick();
    check("hsync_lat2", int'({hsync_out, vsync_out}), 3);
    tick();
    check("hsync_lat3", int'(hsync_out), 0);

    // Randomised commands and pixels.
    rdy_before = 1'b0;
    for (int n = 0; n < 3000; n++) begin
      if (!cmd_if.valid || rdy_before) begin
        int r;
        r = int'($urandom_range(0, 15));
        cmd_if.valid = ($urandom_range(0, 2) == 0);
        cmd_if.op = (r == 0) ? 2'b10 : (r == 1) ? 2'b11 : (r < 5) ? 2'b01 : 2'b00;
        cmd_if.code = 5'($urandom_range(0, 31));
      end
      pix_x = 10'($urandom_range(0, 700));
      pix_y = 10'(Y0 - 2 + int'($urandom_range(0, 35)));
      de_in = ($urandom_range(0, 7) != 0);
      hsync_in = 1'($urandom_range(0, 1));
      vsync_in = 1'($urandom_range(0, 1));
      rdy_before = cmd_if.ready;
      tick();
    end
    cnt = 0;
    while (!cmd_if.ready && cnt < 100) begin
      cnt++;
      tick();
    end
    cmd_if.valid = 1'b0;

    // Async reset mid-clear and mid-frame.
    for (int i = 0; i < 6; i++) do_cmd(2'b00, 5'(i + 1));
    pix_x = 10'd20; pix_y = 10'(Y0 + 4); de_in = 1'b1; hsync_in = 1'b1; vsync_in = 1'b1;
    do_cmd(2'b10, 5'd0);
    tick(); tick(); tick();
    #1;
    rst = 1'b0;
    #1;
    check("rst_async_render", int'({pix_on, de_out, hsync_out, vsync_out}), 0);
    check("rst_async_rom", int'(rom_address), 0);
    check("rst_async_state", int'({busy, cursor}), 0);
    tick(); tick();
    rst = 1'b1;
    tick();
    check("post_rst_state", int'({busy, cursor}), 0);
    hsync_in = 1'b0; vsync_in = 1'b0;
    pix_y = 10'(Y0 + 16);
    sum = 0;
    for (int x = 0; x < 16 * NC + 2; x++) begin
      if (x >= 2) sum += int'(pix_on);
      pix_x = 10'(x);
      tick();
    end
    check("post_rst_blank", sum, 0);

    tick(); tick();
    chk_en = 0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/text_line_ctrl.md
Name: text_line_ctrl

Overview:
- Sequences the 27-entry glyph ROM (`rom_1`: 16x32 glyphs, codes 1..26 = A..Z, code 0 = blank) for one line of text on the VGA output.
- Owns a character buffer that the keyboard decoder fills through a valid/ready command interface.
- Each cycle, maps the current VGA pixel coordinate to a buffer cell and glyph row/column, drives the ROM address, and extracts the pixel bit.
- Outputs the pixel together with timing signals delayed to match.

Parameters:
- NUM_CHARS, 40, number of character cells in the line (40*16 = 640 px).
- X0, 0, left pixel column of the text line.
- Y0, 224, top pixel row of the text line.

Ports:
- clk  in  1  pixel clock.
- rst  in  1  asynchronous, active-low reset.
- cmd_valid  in  1  keyboard command valid.
- cmd_ready  out  1  command accepted when cmd_valid && cmd_ready.
- cmd_op  in  2  00 put char, 01 backspace, 10 clear, 11 reserved.
- cmd_code  in  5  character code for put.
- pix_x  in  10  current pixel column from VGA timing.
- pix_y  in  10  current pixel row.
- de_in  in  1  display-enable.
- hsync_in  in  1  horizontal sync.
- vsync_in  in  1  vertical sync.
- rom_address  out  10  to glyph ROM address.
- rom_data  in  512  glyph ROM data (combinational from address).
- pix_on  out  1  foreground pixel.
- de_out  out  1  display-enable delayed 2 cycles.
- hsync_out  out  1  horizontal sync delayed 2 cycles.
- vsync_out  out  1  vertical sync delayed 2 cycles.
- cursor  out  6  next write cell, 0..NUM_CHARS.
- busy  out  1  high while a clear is in progress.

Behaviour:
- Reset (rst low, async): all buffer cells = 0, cursor = 0, FSM = IDLE, busy = 0. All pipeline registers = 0, so pix_on = de_out = hsync_out = vsync_out = 0 and rom_address = 0.
- cmd_ready = (state == IDLE). A command executes in the cycle it is accepted.
- Put:
  - If cursor < NUM_CHARS: buf[cursor] <= (cmd_code <= 26 ? cmd_code : 0), cursor++.
  - If cursor == NUM_CHARS: accepted and dropped; nothing changes.
- Backspace:
  - If cursor > 0: cursor--, buf[cursor-1] <= 0.
  - If cursor == 0: accepted, no-op.
- Reserved op (11): accepted, no-op.
- Clear: accepted in IDLE, then FSM -> CLEAR with clr_idx = 0 and busy = 1.
  - Each CLEAR cycle: buf[clr_idx] <= 0, clr_idx++.
  - After the cycle that writes index NUM_CHARS-1: cursor <= 0, FSM -> IDLE, busy <= 0.
  - Clear takes exactly NUM_CHARS cycles; cmd_ready is low throughout. Commands presented meanwhile are held by the sender, never lost.
- Render pipeline (free-running, independent of the FSM):
  - Stage 1 registers:
    - in_text = de_in && X0 <= pix_x < X0+16*NUM_CHARS && Y0 <= pix_y < Y0+32.
    - cell = (pix_x-X0)>>4, col = (pix_x-X0)[3:0], row = (pix_y-Y0)[4:0].
    - code = in_text ? buf[cell] : 0. The buffer read returns the pre-write value when a write hits the same cell in the same cycle.
    - de, hsync, vsync.
  - rom_address = {5'b0, stage1 code} (combinational from the stage-1 register).
  - Stage 2 registers:
    - pix_on = in_text1 && rom_data[row1*16 + col1]. Glyph bit mapping: row r occupies bits [r*16+15 : r*16], row 0 = top; bit 0 of a row = leftmost column.
    - de, hsync, vsync copied from stage 1.
  - Latency: inputs at cycle N appear on the outputs after edge N+2. Sync polarity is passed through unchanged.
- Subtraction and compare are done at 11 bits so pix_x < X0 never wraps into range.
- A clear mid-frame may leave the line partially blank for that frame; this is acceptable.
- Reset asserted mid-clear returns to IDLE with the buffer zeroed.

Test Plan:
- Reset, then put codes 1, 2, 3 -> cursor = 3. Scan y = Y0+16, x = 0..47: pix_on follows A/B/C row 16, two cycles after each pixel. At cell 0 (A, crossbar row), x = 2..13 are on.
- Put 41 times -> cursor saturates at 40, 41st accepted with no change. Put code 30 at cell 0 after a clear -> stored as 0, blank cell.
- Backspace at cursor 0 -> no change. Put 5 then backspace -> cursor = 0, buf[0] = 0, cell 0 renders blank.
- Clear with cursor = 40 -> busy = 1 and cmd_ready = 0 for exactly 40 cycles. A put held during that time is accepted on the first IDLE cycle and written to cell 0.
- Pixel outside the line (y = Y0-1, y = Y0+32, x = 640, de_in = 0) -> pix_on = 0 and rom_address = 0. hsync/vsync/de toggles reappear exactly 2 cycles later.
- Drop rst mid-clear and mid-frame -> all outputs 0 immediately (asynchronously). After release: cursor = 0, busy = 0, every cell renders blank.
